// File: rtl/image_frame_sched.sv
// Ping-pong frame store: the producer stream fills the back buffer, and the display and
// classifier read the front buffer. The buffers exchange only on a display frame tick.
//
// state   | meaning
// FILL    | accepting pixels into the back buffer
// PENDING | back buffer complete, waiting for frame_tick to swap
module image_frame_sched #(
  parameter int WIDTH  = 28,
  parameter int HEIGHT = 28,
  localparam int NPIX  = WIDTH * HEIGHT
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_data,
  input  logic                 in_sof,
  input  logic                 frame_tick,
  input  logic [9:0]           rd_x,
  input  logic [8:0]           rd_y,
  output logic [7:0]           rd_pixel,
  output logic [NPIX-1:0][7:0] image_out,
  output logic                 frame_valid,
  output logic                 swap_pulse,
  output logic [7:0]           frame_count
);

  localparam int AW = ($clog2(NPIX) > 10) ? $clog2(NPIX) : 10;
  localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);

  localparam logic [0:0] FILL    = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0]           state;
  logic                 sel;
  logic [AW-1:0]        wr_addr;
  logic [AW-1:0]        wr_idx;
  logic [NPIX-1:0][7:0] buf0;
  logic [NPIX-1:0][7:0] buf1;
  logic [NPIX-1:0][7:0] front;
  logic [AW-1:0]        rd_idx;
  logic                 rd_in_range;

  // sel=0 presents buf0 and fills buf1; sel=1 does the opposite
  assign front     = sel ? buf1 : buf0;
  assign image_out = front;
  assign in_ready  = (state == FILL);

  assign wr_idx = in_sof ? '0 : wr_addr;

  // The range check is on the coordinates, so an in-range index cannot overflow AW bits
  assign rd_in_range = (rd_x < 10'(WIDTH)) && (rd_y < 9'(HEIGHT));
  assign rd_idx      = AW'(rd_y) * AW'(WIDTH) + AW'(rd_x);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf0        <= '0;
      buf1        <= '0;
      sel         <= 1'b0;
      wr_addr     <= '0;
      state       <= FILL;
      rd_pixel    <= 8'd0;
      frame_valid <= 1'b0;
      swap_pulse  <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      swap_pulse <= 1'b0;
      rd_pixel   <= rd_in_range ? front[rd_idx] : 8'd0;

      if (state == FILL) begin
        if (in_valid) begin
          if (sel) buf0[wr_idx] <= in_data;
          else     buf1[wr_idx] <= in_data;

          // in_sof resynchronises to pixel 0, even on the last slot
          if (in_sof) begin
            wr_addr <= AW'(1);
          end else if (wr_addr == LAST_ADDR) begin
            wr_addr <= '0;
            state   <= PENDING;
          end else begin
            wr_addr <= wr_addr + AW'(1);
          end
        end
      end else if (frame_tick) begin
        sel         <= ~sel;
        state       <= FILL;
        swap_pulse  <= 1'b1;
        frame_count <= frame_count + 8'd1;
        frame_valid <= 1'b1;
      end
    end
  end

endmodule
